// File: rtl/l2_bus_arbiter.sv
// ---------------------------------------------------------------------------
// l2_bus_arbiter
//
// Purpose:
//   Arbitrates a single shared L2 port between two L1 cores. A core is granted
//   the bus from IDLE, keeps it for as long as it holds any request, and then
//   gives the bus up through a one-cycle RELEASE state before the next
//   arbitration. When both cores request at once, a 1-bit round-robin pointer
//   chooses the winner. In the first cycle of a grant, the winner's request is
//   shown to the other core as a snoop pulse carrying the block tag and index.
//   L2_busy_in stalls the arbiter. While it is high, state, pointer and
//   counters hold their values.
//
// Ports:
//   clk                        single clock, rising edge
//   reset                      asynchronous, active-low reset
//   cX_L2_read_request         core X read request            (X = 0,1)
//   cX_L2_write_request        core X write request
//   cX_L2_word_address [14:0]  core X word address
//   cX_L2_write_word   [n-1:0] core X write data
//   L2_busy_in                 stall from the shared L2
//   L2_read_request            muxed read request to L2 (read wins over write)
//   L2_write_request           muxed write request to L2
//   L2_word_address    [14:0]  muxed address to L2
//   L2_write_word      [n-1:0] muxed write data to L2
//   cX_L2_busy                 per-core stall
//   cX_others_read_request     snoop pulse: the other core started a read
//   cX_others_write_request    snoop pulse: the other core started a write
//   cX_others_block_tag  [4:0] snooped address[14:10]
//   cX_others_block_index[5:0] snooped address[9:4]
//   arb_statistics     [31:0]  {grant0, grant1, conflict, snoop} 8-bit counters
// ---------------------------------------------------------------------------
module l2_bus_arbiter #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         c0_L2_read_request,
  input  logic         c1_L2_read_request,
  input  logic         c0_L2_write_request,
  input  logic         c1_L2_write_request,
  input  logic [14:0]  c0_L2_word_address,
  input  logic [14:0]  c1_L2_word_address,
  input  logic [n-1:0] c0_L2_write_word,
  input  logic [n-1:0] c1_L2_write_word,
  input  logic         L2_busy_in,
  output logic         L2_read_request,
  output logic         L2_write_request,
  output logic [14:0]  L2_word_address,
  output logic [n-1:0] L2_write_word,
  output logic         c0_L2_busy,
  output logic         c1_L2_busy,
  output logic         c0_others_read_request,
  output logic         c0_others_write_request,
  output logic         c1_others_read_request,
  output logic         c1_others_write_request,
  output logic [4:0]   c0_others_block_tag,
  output logic [4:0]   c1_others_block_tag,
  output logic [5:0]   c0_others_block_index,
  output logic [5:0]   c1_others_block_index,
  output logic [31:0]  arb_statistics
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT0    = 2'd1,
    GNT1    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state_reg, state_next;
  logic   rr_reg, rr_next;
  // High during the first cycle of a grant. It is frozen by a stall like the
  // rest of the state, so a stalled first cycle keeps its snoop pulse and the
  // pulse is counted once.
  logic   first_reg, first_next;

  logic [7:0] grant0_cnt_reg, grant0_cnt_next;
  logic [7:0] grant1_cnt_reg, grant1_cnt_next;
  logic [7:0] conflict_cnt_reg, conflict_cnt_next;
  logic [7:0] snoop_cnt_reg, snoop_cnt_next;

  // Per-core views of the inputs, indexed by core number.
  logic [1:0]         rd, wr, req, gnt;
  logic [1:0][14:0]   addr;
  logic [1:0][n-1:0]  wdata;
  logic               owner;      // index of the granted core, valid when |gnt
  logic               win;        // winner chosen in IDLE

  // Snoop outputs, indexed by the core that receives the snoop.
  logic [1:0]         snoop_rd, snoop_wr, snoop_pulse;
  logic [1:0][4:0]    snoop_tag;
  logic [1:0][5:0]    snoop_index;

  assign rd    = {c1_L2_read_request,  c0_L2_read_request};
  assign wr    = {c1_L2_write_request, c0_L2_write_request};
  assign addr  = {c1_L2_word_address,  c0_L2_word_address};
  assign wdata = {c1_L2_write_word,    c0_L2_write_word};
  assign req   = rd | wr;

  assign gnt[0] = (state_reg == GNT0);
  assign gnt[1] = (state_reg == GNT1);
  assign owner  = gnt[1];

  // -------------------------------------------------------------------------
  // Snoop path. Core gi is told about the other core (SRC). The tag and
  // index go straight through during the pulse. Otherwise they show the
  // value captured by the last pulse.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_snoop
    localparam int SRC = 1 - gi;

    logic [4:0] tag_reg;
    logic [5:0] index_reg;

    assign snoop_rd[gi]    = gnt[SRC] & first_reg & rd[SRC];
    assign snoop_wr[gi]    = gnt[SRC] & first_reg & wr[SRC];
    assign snoop_pulse[gi] = snoop_rd[gi] | snoop_wr[gi];

    // A pulse can only end on an edge without a stall, so capturing on
    // un-stalled edges always keeps the value of the last pulse cycle.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        tag_reg   <= '0;
        index_reg <= '0;
      end else if (snoop_pulse[gi] && !L2_busy_in) begin
        tag_reg   <= addr[SRC][14:10];
        index_reg <= addr[SRC][9:4];
      end
    end

    assign snoop_tag[gi]   = snoop_pulse[gi] ? addr[SRC][14:10] : tag_reg;
    assign snoop_index[gi] = snoop_pulse[gi] ? addr[SRC][9:4]   : index_reg;
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      rr_reg           <= 1'b0;
      first_reg        <= 1'b0;
      grant0_cnt_reg   <= '0;
      grant1_cnt_reg   <= '0;
      conflict_cnt_reg <= '0;
      snoop_cnt_reg    <= '0;
    end else begin
      state_reg        <= state_next;
      rr_reg           <= rr_next;
      first_reg        <= first_next;
      grant0_cnt_reg   <= grant0_cnt_next;
      grant1_cnt_reg   <= grant1_cnt_next;
      conflict_cnt_reg <= conflict_cnt_next;
      snoop_cnt_reg    <= snoop_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. Everything holds while L2 is busy.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    rr_next           = rr_reg;
    first_next        = first_reg;
    grant0_cnt_next   = grant0_cnt_reg;
    grant1_cnt_next   = grant1_cnt_reg;
    conflict_cnt_next = conflict_cnt_reg;
    snoop_cnt_next    = snoop_cnt_reg;
    win               = 1'b0;

    if (!L2_busy_in) begin
      first_next = 1'b0;
      // The two snoop outputs are never active in the same cycle.
      // One pulse therefore counts once.
      if (|snoop_pulse) begin
        snoop_cnt_next = snoop_cnt_reg + 8'd1;
      end

      case (state_reg)
        IDLE: begin
          if (req != 2'b00) begin
            // With a single requester, that requester wins. On a tie, rr picks.
            win        = (req == 2'b11) ? rr_reg : req[1];
            state_next = win ? GNT1 : GNT0;
            rr_next    = ~win;
            first_next = 1'b1;
            if (win) begin
              grant1_cnt_next = grant1_cnt_reg + 8'd1;
            end else begin
              grant0_cnt_next = grant0_cnt_reg + 8'd1;
            end
            if (req == 2'b11) begin
              conflict_cnt_next = conflict_cnt_reg + 8'd1;
            end
          end
        end
        GNT0: begin
          if (!req[0]) begin
            state_next = RELEASE;
          end
        end
        GNT1: begin
          if (!req[1]) begin
            state_next = RELEASE;
          end
        end
        RELEASE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. Several outputs depend directly on the core inputs. They are
  // gated by reset so that every output is 0 while reset is asserted.
  // -------------------------------------------------------------------------
  always_comb begin
    L2_read_request         = 1'b0;
    L2_write_request        = 1'b0;
    L2_word_address         = '0;
    L2_write_word           = '0;
    c0_L2_busy              = 1'b0;
    c1_L2_busy              = 1'b0;
    c0_others_read_request  = 1'b0;
    c0_others_write_request = 1'b0;
    c1_others_read_request  = 1'b0;
    c1_others_write_request = 1'b0;
    c0_others_block_tag     = '0;
    c1_others_block_tag     = '0;
    c0_others_block_index   = '0;
    c1_others_block_index   = '0;
    arb_statistics          = '0;

    if (reset) begin
      if (gnt != 2'b00) begin
        L2_read_request  = rd[owner];
        L2_write_request = wr[owner] & ~rd[owner];
        L2_word_address  = addr[owner];
        L2_write_word    = wdata[owner];
      end

      // The granted core sees the L2 stall. Any other core is stalled only
      // if it is asking for the bus.
      c0_L2_busy = gnt[0] ? L2_busy_in : req[0];
      c1_L2_busy = gnt[1] ? L2_busy_in : req[1];

      c0_others_read_request  = snoop_rd[0];
      c0_others_write_request = snoop_wr[0];
      c1_others_read_request  = snoop_rd[1];
      c1_others_write_request = snoop_wr[1];
      c0_others_block_tag     = snoop_tag[0];
      c1_others_block_tag     = snoop_tag[1];
      c0_others_block_index   = snoop_index[0];
      c1_others_block_index   = snoop_index[1];

      arb_statistics = {grant0_cnt_reg, grant1_cnt_reg,
                        conflict_cnt_reg, snoop_cnt_reg};
    end
  end

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l2_bus_arbiter
//
// Purpose:
//   Scoreboard bench for l2_bus_arbiter. Each cycle, the driver applies one
//   input vector and asks a behavioural model (bus owner, turnaround flag,
//   integer counters) for the outputs it expects in that cycle. The driver
//   pushes those expected outputs into a queue. A separate monitor pops one
//   entry on every falling edge and compares it with the DUT. Directed
//   scenarios run first, followed by randomized traffic.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_l2_bus_arbiter;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         c0_rd = 1'b0, c1_rd = 1'b0, c0_wr = 1'b0, c1_wr = 1'b0;
  logic [14:0]  c0_addr = '0, c1_addr = '0;
  logic [N-1:0] c0_wd = '0, c1_wd = '0;
  logic         busy_in = 1'b0;

  logic         L2_read_request, L2_write_request;
  logic [14:0]  L2_word_address;
  logic [N-1:0] L2_write_word;
  logic         c0_L2_busy, c1_L2_busy;
  logic         c0_o_rd, c0_o_wr, c1_o_rd, c1_o_wr;
  logic [4:0]   c0_tag, c1_tag;
  logic [5:0]   c0_idx, c1_idx;
  logic [31:0]  arb_statistics;

  always #5 clk = ~clk;

  l2_bus_arbiter #(.n(N)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .c0_L2_read_request      (c0_rd),
    .c1_L2_read_request      (c1_rd),
    .c0_L2_write_request     (c0_wr),
    .c1_L2_write_request     (c1_wr),
    .c0_L2_word_address      (c0_addr),
    .c1_L2_word_address      (c1_addr),
    .c0_L2_write_word        (c0_wd),
    .c1_L2_write_word        (c1_wd),
    .L2_busy_in              (busy_in),
    .L2_read_request         (L2_read_request),
    .L2_write_request        (L2_write_request),
    .L2_word_address         (L2_word_address),
    .L2_write_word           (L2_write_word),
    .c0_L2_busy              (c0_L2_busy),
    .c1_L2_busy              (c1_L2_busy),
    .c0_others_read_request  (c0_o_rd),
    .c0_others_write_request (c0_o_wr),
    .c1_others_read_request  (c1_o_rd),
    .c1_others_write_request (c1_o_wr),
    .c0_others_block_tag     (c0_tag),
    .c1_others_block_tag     (c1_tag),
    .c0_others_block_index   (c0_idx),
    .c1_others_block_index   (c1_idx),
    .arb_statistics          (arb_statistics)
  );

  typedef struct packed {
    logic         l2_rd;
    logic         l2_wr;
    logic [14:0]  l2_addr;
    logic [N-1:0] l2_wd;
    logic [1:0]   busy;
    logic [1:0]   o_rd;
    logic [1:0]   o_wr;
    logic [4:0]   tag0;
    logic [4:0]   tag1;
    logic [5:0]   idx0;
    logic [5:0]   idx1;
    logic [31:0]  stats;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Behavioural model: owner = -1 when nobody holds the bus.
  int         m_owner = -1;
  bit         m_release = 1'b0;   // in the one-cycle turnaround
  bit         m_fresh = 1'b0;     // first cycle of the current grant
  int         m_rr = 0;
  int         m_g0 = 0, m_g1 = 0, m_conf = 0, m_snoop = 0;
  logic [4:0] m_tag [2] = '{5'd0, 5'd0};
  logic [5:0] m_idx [2] = '{6'd0, 6'd0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_release = 1'b0; m_fresh = 1'b0; m_rr = 0;
    m_g0 = 0; m_g1 = 0; m_conf = 0; m_snoop = 0;
    m_tag[0] = '0; m_tag[1] = '0; m_idx[0] = '0; m_idx[1] = '0;
  endtask

  // Applies one cycle of stimulus. Pushes the expected outputs for that
  // cycle, then advances the model past the next rising edge.
  task automatic cycle(input bit rst, input bit r0, input bit w0,
                       input logic [14:0] a0, input logic [N-1:0] d0,
                       input bit r1, input bit w1,
                       input logic [14:0] a1, input logic [N-1:0] d1,
                       input bit bsy);
    exp_t         e;
    bit   [1:0]   rdv, wrv, rq;
    logic [14:0]  av [2];
    logic [N-1:0] dv [2];
    bit           pulse;
    int           tgt, pick;
    @(posedge clk);
    #1;
    reset = rst; busy_in = bsy;
    c0_rd = r0; c0_wr = w0; c0_addr = a0; c0_wd = d0;
    c1_rd = r1; c1_wr = w1; c1_addr = a1; c1_wd = d1;

    rdv = {r1, r0}; wrv = {w1, w0}; rq = rdv | wrv;
    av[0] = a0; av[1] = a1; dv[0] = d0; dv[1] = d1;
    e = '0; pulse = 1'b0; tgt = 0;
    if (rst) begin
      if (m_owner >= 0) begin
        e.l2_rd   = rdv[m_owner];
        e.l2_wr   = wrv[m_owner] && !rdv[m_owner];
        e.l2_addr = av[m_owner];
        e.l2_wd   = dv[m_owner];
      end
      for (int c = 0; c < 2; c++) e.busy[c] = (c == m_owner) ? bsy : rq[c];
      e.tag0 = m_tag[0]; e.tag1 = m_tag[1]; e.idx0 = m_idx[0]; e.idx1 = m_idx[1];
      if (m_owner >= 0 && m_fresh) begin
        tgt = 1 - m_owner;
        e.o_rd[tgt] = rdv[m_owner];
        e.o_wr[tgt] = wrv[m_owner];
        pulse = rdv[m_owner] | wrv[m_owner];
        if (pulse) begin
          if (tgt == 0) begin e.tag0 = av[m_owner] >> 10; e.idx0 = av[m_owner] >> 4; end
          else          begin e.tag1 = av[m_owner] >> 10; e.idx1 = av[m_owner] >> 4; end
        end
      end
      e.stats = {8'(m_g0), 8'(m_g1), 8'(m_conf), 8'(m_snoop)};
    end
    exp_q.push_back(e);

    if (!rst) begin
      model_reset();
    end else if (!bsy) begin
      if (pulse) begin
        m_snoop = (m_snoop + 1) % 256;
        m_tag[tgt] = av[m_owner] >> 10;
        m_idx[tgt] = av[m_owner] >> 4;
      end
      if (m_owner >= 0) begin
        m_fresh = 1'b0;
        if (!rq[m_owner]) begin m_owner = -1; m_release = 1'b1; end
      end else if (m_release) begin
        m_release = 1'b0;
      end else if (rq != 2'b00) begin
        pick = (rq == 2'b11) ? m_rr : (rq[1] ? 1 : 0);
        m_owner = pick; m_rr = 1 - pick; m_fresh = 1'b1;
        if (pick == 0) m_g0 = (m_g0 + 1) % 256; else m_g1 = (m_g1 + 1) % 256;
        if (rq == 2'b11) m_conf = (m_conf + 1) % 256;
      end
    end
  endtask

  task automatic idle_cycle(input bit rst);
    cycle(rst, 0, 0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  // Monitor: one scoreboard entry per cycle, compared away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("l2_read_request", 64'(L2_read_request), 64'(e.l2_rd));
        chk("l2_write_request", 64'(L2_write_request), 64'(e.l2_wr));
        chk("l2_word_address", 64'(L2_word_address), 64'(e.l2_addr));
        chk("l2_write_word", 64'(L2_write_word), 64'(e.l2_wd));
        chk("core_busy", 64'({c1_L2_busy, c0_L2_busy}), 64'(e.busy));
        chk("others_read", 64'({c1_o_rd, c0_o_rd}), 64'(e.o_rd));
        chk("others_write", 64'({c1_o_wr, c0_o_wr}), 64'(e.o_wr));
        chk("others_tag", 64'({c1_tag, c0_tag}), 64'({e.tag1, e.tag0}));
        chk("others_index", 64'({c1_idx, c0_idx}), 64'({e.idx1, e.idx0}));
        chk("arb_statistics", 64'(arb_statistics), 64'(e.stats));
      end
    end
  end

  initial begin
    bit r0, w0, r1, w1, bsy, rst;
    logic [14:0] a0, a1;
    logic [N-1:0] d0, d1;

    repeat (3) idle_cycle(0);

    // Core0 reads 0x1234 for 17 cycles.
    cycle(1, 1, 0, 15'h1234, 32'hAAAA0001, 0, 0, '0, '0, 0);
    cycle(1, 1, 0, 15'h1234, 32'hAAAA0001, 0, 0, '0, '0, 0);
    #2;
    chk("t029_snoop_pulse", 64'(c1_o_rd), 64'd1);
    chk("t029_tag", 64'(c1_tag), 64'h04);
    chk("t029_index", 64'(c1_idx), 64'h23);
    chk("t029_c1_busy", 64'(c1_L2_busy), 64'd0);
    cycle(1, 1, 0, 15'h1234, 32'hAAAA0001, 0, 0, '0, '0, 0);
    #2;
    chk("t029_pulse_ends", 64'(c1_o_rd), 64'd0);
    repeat (14) cycle(1, 1, 0, 15'h1234, 32'hAAAA0001, 0, 0, '0, '0, 0);
    repeat (3) idle_cycle(1);
    #2;
    chk("t029_grant0_cnt", 64'(arb_statistics[31:24]), 64'd1);

    // Simultaneous requests after reset: core0 first, then core1 (write).
    idle_cycle(0);
    cycle(1, 1, 0, 15'h0100, 32'h11, 0, 1, 15'h7FF0, 32'hC0DE0001, 0);
    repeat (3) begin
      cycle(1, 1, 0, 15'h0100, 32'h11, 0, 1, 15'h7FF0, 32'hC0DE0001, 0);
      #2;
      chk("t030_c1_busy", 64'(c1_L2_busy), 64'd1);
    end
    repeat (3) cycle(1, 0, 0, '0, '0, 0, 1, 15'h7FF0, 32'hC0DE0001, 0);
    cycle(1, 0, 0, '0, '0, 0, 1, 15'h7FF0, 32'hC0DE0001, 0);
    #2;
    chk("t031_wdata", 64'(L2_write_word), 64'hC0DE0001);
    chk("t031_snoop_wr", 64'(c0_o_wr), 64'd1);
    cycle(1, 0, 0, '0, '0, 0, 1, 15'h7FF0, 32'hC0DE0001, 0);
    #2;
    chk("t031_snoop_once", 64'(c0_o_wr), 64'd0);
    repeat (3) idle_cycle(1);
    #2;
    chk("t030_conflict_cnt", 64'(arb_statistics[15:8]), 64'd1);

    // L2 stall for 5 cycles in the middle of a GNT0.
    repeat (3) cycle(1, 1, 0, 15'h2222, 32'h5, 0, 0, '0, '0, 0);
    repeat (5) begin
      cycle(1, 1, 0, 15'h2222, 32'h5, 0, 0, '0, '0, 1);
      #2;
      chk("t032_c0_busy", 64'(c0_L2_busy), 64'd1);
    end
    repeat (2) cycle(1, 1, 0, 15'h2222, 32'h5, 0, 0, '0, '0, 0);
    repeat (3) idle_cycle(1);

    // Reset in the middle of a GNT1, then a dual request.
    repeat (3) cycle(1, 0, 0, '0, '0, 1, 0, 15'h0ABC, 32'h9, 0);
    cycle(0, 0, 0, '0, '0, 1, 0, 15'h0ABC, 32'h9, 0);
    #2;
    chk("t033_busy_zero", 64'(c1_L2_busy), 64'd0);
    chk("t033_stats_zero", 64'(arb_statistics), 64'd0);
    cycle(1, 1, 0, 15'h0333, 32'h1, 1, 0, 15'h0ABC, 32'h9, 0);
    cycle(1, 1, 0, 15'h0333, 32'h1, 1, 0, 15'h0ABC, 32'h9, 0);
    #2;
    chk("t033_core0_wins", 64'(L2_word_address), 64'h0333);
    repeat (3) idle_cycle(1);

    // 256 core0 grants wrap the counter.
    idle_cycle(0);
    for (int i = 0; i < 256; i++) begin
      cycle(1, 0, 1, 15'(i), 32'(i), 0, 0, '0, '0, 0);
      idle_cycle(1);
      idle_cycle(1);
    end
    #2;
    chk("t034_grant0_wrap", 64'(arb_statistics[31:24]), 64'd0);

    // Randomized traffic with sticky requests, stalls and rare resets.
    r0 = 0; w0 = 0; r1 = 0; w1 = 0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) r0 = !r0;
      if ($urandom_range(0, 3) == 0) w0 = !w0;
      if ($urandom_range(0, 3) == 0) r1 = !r1;
      if ($urandom_range(0, 3) == 0) w1 = !w1;
      if ($urandom_range(0, 2) == 0) a0 = 15'($urandom);
      if ($urandom_range(0, 2) == 0) a1 = 15'($urandom);
      d0 = $urandom; d1 = $urandom;
      bsy = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 149) != 0);
      cycle(rst, r0, w0, a0, d0, r1, w1, a1, d1, bsy);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/l2_bus_arbiter.md
L2_BUS_ARBITER -- requirements
Module: l2_bus_arbiter

Interface
REQ-001 SHALL have parameter n, default 32, meaning L2 data word width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have ports c0_L2_read_request, c1_L2_read_request  input  1 each  per-core L1 read request.
REQ-005 SHALL have ports c0_L2_write_request, c1_L2_write_request  input  1 each  per-core L1 write request.
REQ-006 SHALL have ports c0_L2_word_address, c1_L2_word_address  input  15 each  per-core word address.
REQ-007 SHALL have ports c0_L2_write_word, c1_L2_write_word  input  n each  per-core write data.
REQ-008 SHALL have port L2_busy_in  input  1  clock-enable/stall from the shared L2.
REQ-009 SHALL have ports L2_read_request, L2_write_request  output  1 each  muxed request to L2.
REQ-010 SHALL have ports L2_word_address (15) and L2_write_word (n)  output  muxed address/data to L2.
REQ-011 SHALL have ports c0_L2_busy, c1_L2_busy  output  1 each  per-core stall.
REQ-012 SHALL have ports c0_others_read_request, c0_others_write_request, c1_others_read_request, c1_others_write_request  output  1 each  snoop pulses into each core.
REQ-013 SHALL have ports cX_others_block_tag (5) and cX_others_block_index (6), X=0,1  output  snoop tag/index.
REQ-014 SHALL have port arb_statistics  output  32  {grant0_cnt[7:0], grant1_cnt[7:0], conflict_cnt[7:0], snoop_cnt[7:0]}.

Function
REQ-015 SHALL implement registered FSM with states IDLE, GNT0, GNT1, RELEASE.
REQ-016 A core "requests" when its read or write request is 1; if both are 1, read SHALL take precedence for the muxed L2 request.
REQ-017 In IDLE: if exactly one core requests, next state SHALL be that core's GNT; if both request, next state SHALL be GNT of the core selected by 1-bit round-robin pointer rr (0 = core0); if none, stay IDLE.
REQ-018 On the IDLE->GNTx transition, rr SHALL be set to the other core, and conflict_cnt SHALL increment if both requested.
REQ-019 In GNTx: L2_read_request, L2_write_request, L2_word_address, L2_write_word SHALL combinationally follow core x; cx_L2_busy SHALL equal L2_busy_in.
REQ-020 In any state other than GNTx, the L2 request outputs SHALL be 0 and L2_word_address/L2_write_word SHALL be 0.
REQ-021 A core that requests but is not granted SHALL see its cX_L2_busy = 1; a non-requesting, non-granted core SHALL see 0.
REQ-022 In the first cycle of GNTx only, the other core's others_read_request/others_write_request SHALL mirror core x's read/write request, with tag = address[14:10], index = address[9:4]; in every other cycle those request outputs SHALL be 0 (tag/index hold last value); snoop_cnt SHALL increment per pulse.
REQ-023 GNTx SHALL be held while core x requests, regardless of the other core; the first cycle core x requests nothing SHALL move the FSM to RELEASE.
REQ-024 RELEASE SHALL last exactly one cycle, drive no L2 request, then return to IDLE (one-cycle bus turnaround).
REQ-025 When L2_busy_in = 1, state, rr and counters SHALL freeze; outputs per REQ-019/021 still apply.
REQ-026 grantX_cnt SHALL increment on each IDLE->GNTx transition; all 8-bit counters SHALL wrap 255->0.

Reset
REQ-027 While reset = 0: state = IDLE, rr = 0, all counters = 0, snoop tag/index = 0, all outputs 0, asynchronously and regardless of clk or L2_busy_in.
REQ-028 Reset asserted mid-grant SHALL abort the transaction; after release, arbitration restarts from IDLE with core0 priority.

Verification
REQ-029 Core0 read, 17 cycles, address 0x1234 -> GNT0 next cycle; one-cycle c1_others_read_request with tag 0x04, index 0x23; c1_L2_busy = 0; RELEASE then IDLE; grant0_cnt = 1.
REQ-030 Both cores request in same cycle after reset -> core0 granted, c1_L2_busy = 1 throughout; after RELEASE core1 granted; conflict_cnt = 1.
REQ-031 Core1 write (2 cycles) while core0 idle -> c0_others_write_request pulse exactly one cycle; L2_write_word equals c1_L2_write_word during GNT1.
REQ-032 L2_busy_in = 1 for 5 cycles mid-GNT0 -> state/counters frozen, c0_L2_busy = 1; grant resumes afterwards.
REQ-033 Reset pulsed low during GNT1 -> all outputs 0 immediately; rr = 0; next dual request grants core0.
REQ-034 256 core0 grants -> grant0_cnt wraps to 0.
